ifu: RTL

IFU -- requirements
Module: ifu

---
 rtl/ifu_if.sv | 33 +++
 rtl/ifu.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ifu_if.sv
// IFU bus bundle: PC register link, instruction-memory request/response
// channels and the decode-side instruction handshake.
// master = the fetch unit, slave = its environment (PC, memory, decode).
interface ifu_if;
  logic [31:0] pc;
  logic        pc_advance;
  logic        flush;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  modport master (
    input  pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           imem_rsp_err, inst_ready,
    output pc_advance, imem_req_valid, imem_req_addr, inst_valid, inst,
           inst_pc, inst_fault
  );

  modport slave (
    output pc, flush, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           imem_rsp_err, inst_ready,
    input  pc_advance, imem_req_valid, imem_req_addr, inst_valid, inst,
           inst_pc, inst_fault
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: one outstanding memory read at a time, result held
// for decode until accepted or flushed.
// Optional feature: define IFU_MISALIGN_CHECK_EN to turn a misaligned pc into
// a locally generated fetch fault instead of a memory request.
// The request address is taken straight from pc in the first REQ cycle (the
// PC register updates on the same edge that enters REQ) and held from the
// register afterwards, so it stays stable for the whole request.
module ifu (
  input  logic  clk,
  input  logic  rst,
  ifu_if.master bus
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DROP = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic        entry_r, entry_s;
  logic        flush_seen_r, flush_seen_s;
  logic [31:0] req_addr_r;
  logic [31:0] inst_r, inst_pc_r;
  logic        inst_fault_r;

  logic        load_s;
  logic [31:0] load_inst_s, load_pc_s;
  logic        load_fault_s;
  logic        pc_advance_s;
  logic        req_valid_s;
  logic        handshake_s;
  logic        misalign_s;
  logic [31:0] aligned_pc_s;

  assign aligned_pc_s = {bus.pc[31:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
  assign misalign_s = entry_r && (bus.pc[1:0] != 2'b00);
`else
  assign misalign_s = 1'b0;
`endif

  assign req_valid_s = (state_r == REQ) && !misalign_s && !rst;
  assign handshake_s = req_valid_s && bus.imem_req_ready;

  // Next-state, capture and PC write-enable decode.
  always_comb begin
    state_s      = state_r;
    entry_s      = 1'b0;
    flush_seen_s = flush_seen_r;
    load_s       = 1'b0;
    load_inst_s  = inst_r;
    load_pc_s    = req_addr_r;
    load_fault_s = bus.imem_rsp_err;
    pc_advance_s = 1'b0;
    case (state_r)
      IDLE: begin
        state_s      = REQ;
        entry_s      = 1'b1;
        flush_seen_s = 1'b0;
      end
      REQ: begin
        if (misalign_s) begin
          if (bus.flush) begin
            state_s = REQ;
            entry_s = 1'b1;
          end else begin
            state_s      = HOLD;
            load_s       = 1'b1;
            load_inst_s  = NOP_INST;
            load_pc_s    = bus.pc;
            load_fault_s = 1'b1;
          end
        end else if (handshake_s) begin
          state_s      = (flush_seen_r || bus.flush) ? DROP : WAIT;
          flush_seen_s = 1'b0;
        end else begin
          flush_seen_s = flush_seen_r | bus.flush;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          if (bus.imem_rsp_valid) begin
            state_s = REQ;
            entry_s = 1'b1;
          end else begin
            state_s = DROP;
          end
        end else if (bus.imem_rsp_valid) begin
          state_s     = HOLD;
          load_s      = 1'b1;
          load_inst_s = bus.imem_rsp_data;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        if (bus.imem_rsp_valid) begin
          state_s = REQ;
          entry_s = 1'b1;
        end else begin
          state_s = DROP;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          state_s = REQ;
          entry_s = 1'b1;
        end else if (bus.inst_ready) begin
          state_s      = REQ;
          entry_s      = 1'b1;
          pc_advance_s = 1'b1;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s      = IDLE;
        flush_seen_s = 1'b0;
      end
    endcase
  end

  // State, request address and instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      entry_r      <= 1'b0;
      flush_seen_r <= 1'b0;
      req_addr_r   <= 32'h0000_0000;
      inst_r       <= NOP_INST;
      inst_pc_r    <= 32'h0000_0000;
      inst_fault_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      entry_r      <= entry_s;
      flush_seen_r <= flush_seen_s;
      if (entry_r) begin
        req_addr_r <= aligned_pc_s;
      end
      if (load_s) begin
        inst_r       <= load_inst_s;
        inst_pc_r    <= load_pc_s;
        inst_fault_r <= load_fault_s;
      end
    end
  end

  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = entry_r ? aligned_pc_s : req_addr_r;
  assign bus.inst_valid     = (state_r == HOLD);
  assign bus.inst           = inst_r;
  assign bus.inst_pc        = inst_pc_r;
  assign bus.inst_fault     = inst_fault_r;
  assign bus.pc_advance     = pc_advance_s && !rst;

endmodule
